// File: rtl/iq_rx_packer_if.sv
// Packed-word stream from the RX packer to the AXI2S input (Sin/Ien).
// The producer drives word and valid. The consumer drives ready.
interface iq_rx_packer_if;
  logic [31:0] sout;
  logic        sout_valid;
  logic        sout_ready;

  modport master (output sout, output sout_valid, input sout_ready);
  modport slave  (input sout, input sout_valid, output sout_ready);
endinterface

// File: rtl/iq_rx_packer.sv
// RX-side packer: serialises enabled AD9361 channels into 32-bit words (16b I/Q or
// paired 8b I/Q), buffers them in a first-word-fall-through FIFO, and counts drops.
module iq_rx_packer #(
  parameter int SAMPLE_W   = 12,
  parameter int NCH        = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            mode,
  input  logic [NCH-1:0]                  ch_en,
  input  logic                            rx_ce,
  input  logic [NCH*SAMPLE_W-1:0]         rx_i,
  input  logic [NCH*SAMPLE_W-1:0]         rx_q,
  iq_rx_packer_if.master                  sout_if,
  input  logic                            clr,
  output logic [15:0]                     ovr_cnt,
  output logic [15:0]                     ovf_cnt,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_SER} state_e;

  state_e                  state_q, state_d;
  logic [NCH*SAMPLE_W-1:0] stg_i_q, stg_i_d, stg_q_q, stg_q_d;
  logic [NCH-1:0]          rem_q, rem_d;
  logic                    stg_mode_q, stg_mode_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [15:0]             pend_q, pend_d;
  logic [15:0]             ovr_q, ovr_d, ovf_q, ovf_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [31:0]             mem [FIFO_DEPTH];

  logic                    push_req, push_ok, pop, fifo_vld, ovr_inc, ovf_inc, found;
  logic [31:0]             push_word;
  logic [SAMPLE_W-1:0]     cur_i, cur_q;

  // Serializer: one channel-sample per SER cycle, lowest enabled channel first.
  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    stg_i_d    = stg_i_q;
    stg_q_d    = stg_q_q;
    rem_d      = rem_q;
    stg_mode_d = stg_mode_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    push_req   = 1'b0;
    push_word  = '0;
    ovr_inc    = 1'b0;
    found      = 1'b0;
    cur_i      = '0;
    cur_q      = '0;
    case (state_q)
      S_IDLE: begin
        if (rx_ce && (ch_en != '0)) begin
          stg_i_d    = rx_i;
          stg_q_d    = rx_q;
          rem_d      = ch_en;
          stg_mode_d = mode;
          // A half-word packed under the other mode can never be paired validly.
          if (mode != stg_mode_q) pend_vld_d = 1'b0;
          state_d    = S_SER;
        end
      end
      S_SER: begin
        ovr_inc = rx_ce;
        for (int k = 0; k < NCH; k++) begin
          if (!found && rem_q[k]) begin
            found    = 1'b1;
            cur_i    = stg_i_q[k*SAMPLE_W +: SAMPLE_W];
            cur_q    = stg_q_q[k*SAMPLE_W +: SAMPLE_W];
            rem_d[k] = 1'b0;
          end
        end
        if (!stg_mode_q) begin
          push_req  = 1'b1;
          push_word = {16'($signed(cur_q)), 16'($signed(cur_i))};
        end else if (pend_vld_q) begin
          push_req   = 1'b1;
          push_word  = {cur_q[SAMPLE_W-1 -: 8], cur_i[SAMPLE_W-1 -: 8], pend_q};
          pend_vld_d = 1'b0;
        end else begin
          pend_d     = {cur_q[SAMPLE_W-1 -: 8], cur_i[SAMPLE_W-1 -: 8]};
          pend_vld_d = 1'b1;
        end
        if (rem_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr) pend_vld_d = 1'b0;
  end

  // FIFO control: a full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    fifo_vld = (level_q != '0);
    pop      = fifo_vld && sout_if.sout_ready;
    push_ok  = push_req && ((level_q != FULL_LVL) || pop);
    ovf_inc  = push_req && !push_ok;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop)      level_d = level_q + LW'(1);
    else if (!push_ok && pop) level_d = level_q - LW'(1);
    ovr_d = ovr_q;
    ovf_d = ovf_q;
    if (clr) begin
      ovr_d = '0;
      ovf_d = '0;
    end else begin
      if (ovr_inc && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;
      if (ovf_inc && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      stg_i_q    <= '0;
      stg_q_q    <= '0;
      rem_q      <= '0;
      stg_mode_q <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      ovr_q      <= '0;
      ovf_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      stg_i_q    <= stg_i_d;
      stg_q_q    <= stg_q_d;
      rem_q      <= rem_d;
      stg_mode_q <= stg_mode_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy lives in level_q and sout is gated while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_word;
  end

  assign sout_if.sout       = fifo_vld ? mem[rd_ptr_q] : '0;
  assign sout_if.sout_valid = fifo_vld;
  assign ovr_cnt            = ovr_q;
  assign ovf_cnt            = ovf_q;
  assign fifo_level         = level_q;

endmodule

// File: tb/tb_iq_rx_packer.sv
// Directed, table-driven bench for iq_rx_packer with default parameters.
// A negedge monitor collects every word the consumer accepts.
module tb_iq_rx_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  ch_en = 2'b00;
  logic        rx_ce = 1'b0;
  logic [23:0] rx_i = '0;
  logic [23:0] rx_q = '0;
  logic        clr = 1'b0;
  logic [15:0] ovr_cnt, ovf_cnt;
  logic [4:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] got [$];

  iq_rx_packer_if bus ();

  iq_rx_packer #(.SAMPLE_W(12), .NCH(2), .FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .ch_en      (ch_en),
    .rx_ce      (rx_ce),
    .rx_i       (rx_i),
    .rx_q       (rx_q),
    .sout_if    (bus.master),
    .clr        (clr),
    .ovr_cnt    (ovr_cnt),
    .ovf_cnt    (ovf_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.sout_valid && bus.sout_ready) got.push_back(bus.sout);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        m;
    logic [1:0]  en;
    logic [11:0] i0, q0, i1, q1;
    int          n;
    logic [31:0] w0, w1;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_at(input int idx);
    return (got.size() > idx) ? got[idx] : 32'hxxxx_xxxx;
  endfunction

  task automatic apply_set(input logic m, input logic [1:0] en,
                           input logic [11:0] i0, input logic [11:0] q0,
                           input logic [11:0] i1, input logic [11:0] q1);
    mode  = m;
    ch_en = en;
    rx_i  = {i1, i0};
    rx_q  = {q1, q0};
    rx_ce = 1'b1;
    tick();
    rx_ce = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'b11, 12'h800, 12'h7FF, 12'h001, 12'hFFF, 2, 32'h07FF_F800, 32'hFFFF_0001};
    vecs[1] = '{1'b0, 2'b01, 12'h7FF, 12'h800, 12'h000, 12'h000, 1, 32'hF800_07FF, 32'h0};
    vecs[2] = '{1'b0, 2'b10, 12'h555, 12'hAAA, 12'h123, 12'hABC, 1, 32'hFABC_0123, 32'h0};
    vecs[3] = '{1'b0, 2'b11, 12'h000, 12'h000, 12'hFFF, 12'h801, 2, 32'h0000_0000, 32'hF801_FFFF};
    vecs[4] = '{1'b1, 2'b11, 12'hABC, 12'h123, 12'h456, 12'hFED, 1, 32'hFE45_12AB, 32'h0};

    bus.sout_ready = 1'b1;
    repeat (3) tick();
    check("rst_sout", bus.sout, 32'h0);
    check("rst_valid", 32'(bus.sout_valid), 32'h0);
    check("rst_level", 32'(fifo_level), 32'h0);
    check("rst_ovr", 32'(ovr_cnt), 32'h0);
    check("rst_ovf", 32'(ovf_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // First-word-fall-through latency: capture at E0, word visible after E1.
    apply_set(1'b0, 2'b11, 12'h800, 12'h7FF, 12'h001, 12'hFFF);
    check("lat_e0_valid", 32'(bus.sout_valid), 32'h0);
    tick();
    check("lat_e1_valid", 32'(bus.sout_valid), 32'h1);
    check("lat_e1_sout", bus.sout, 32'h07FF_F800);
    repeat (4) tick();

    foreach (vecs[v]) begin
      got.delete();
      apply_set(vecs[v].m, vecs[v].en, vecs[v].i0, vecs[v].q0, vecs[v].i1, vecs[v].q1);
      repeat (6) tick();
      check($sformatf("vec%0d_count", v), 32'(got.size()), 32'(vecs[v].n));
      check($sformatf("vec%0d_w0", v), word_at(0), vecs[v].w0);
      if (vecs[v].n > 1) check($sformatf("vec%0d_w1", v), word_at(1), vecs[v].w1);
    end

    // Mode 1, one channel: the first set only fills the pending half.
    got.delete();
    apply_set(1'b1, 2'b01, 12'hABC, 12'h123, 12'h000, 12'h000);
    repeat (4) tick();
    check("m1_first_none", 32'(got.size()), 32'h0);
    apply_set(1'b1, 2'b01, 12'h456, 12'hFED, 12'h000, 12'h000);
    repeat (4) tick();
    check("m1_pair_count", 32'(got.size()), 32'h1);
    check("m1_pair_word", word_at(0), 32'hFE45_12AB);

    // Overrun: strobes every 2 cycles with two channels enabled.
    got.delete();
    mode  = 1'b0;
    ch_en = 2'b11;
    rx_i  = {12'h002, 12'h001};
    rx_q  = {12'h004, 12'h003};
    for (int s = 0; s < 6; s++) begin
      rx_ce = 1'b1;
      tick();
      rx_ce = 1'b0;
      tick();
    end
    repeat (4) tick();
    check("ovr_count", 32'(ovr_cnt), 32'd3);
    check("ovr_words", 32'(got.size()), 32'd6);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("ovr_clr", 32'(ovr_cnt), 32'd0);

    // Overflow: 20 words into a 16-deep FIFO with the consumer stalled.
    got.delete();
    bus.sout_ready = 1'b0;
    for (int s = 0; s < 20; s++) begin
      apply_set(1'b0, 2'b01, 12'(s + 1), 12'h000, 12'h000, 12'h000);
      repeat (2) tick();
    end
    check("ovf_level", 32'(fifo_level), 32'd16);
    check("ovf_count", 32'(ovf_cnt), 32'd4);
    check("ovf_hold_sout", bus.sout, 32'h0000_0001);
    apply_set(1'b0, 2'b01, 12'h100, 12'h000, 12'h000, 12'h000);
    bus.sout_ready = 1'b1;
    tick();
    check("full_push_pop_level", 32'(fifo_level), 32'd16);
    check("full_push_pop_ovf", 32'(ovf_cnt), 32'd4);
    check("full_push_pop_sout", bus.sout, 32'h0000_0002);
    repeat (20) tick();
    check("drain_count", 32'(got.size()), 32'd17);
    check("drain_first", word_at(0), 32'h0000_0001);
    check("drain_16th", word_at(15), 32'h0000_0010);
    check("drain_last", word_at(16), 32'h0000_0100);
    check("drain_level", 32'(fifo_level), 32'd0);

    // Reset mid-serialization with a word queued and a pending half held.
    bus.sout_ready = 1'b0;
    apply_set(1'b0, 2'b01, 12'h005, 12'h006, 12'h000, 12'h000);
    repeat (2) tick();
    apply_set(1'b1, 2'b01, 12'h111, 12'h222, 12'h000, 12'h000);
    repeat (2) tick();
    apply_set(1'b1, 2'b11, 12'h333, 12'h444, 12'h555, 12'h666);
    rst_n = 1'b0;
    #1;
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_valid", 32'(bus.sout_valid), 32'd0);
    check("midrst_sout", bus.sout, 32'h0);
    check("midrst_ovf", 32'(ovf_cnt), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    got.delete();
    bus.sout_ready = 1'b1;
    apply_set(1'b1, 2'b01, 12'h456, 12'hFED, 12'h000, 12'h000);
    repeat (2) tick();
    apply_set(1'b1, 2'b01, 12'hABC, 12'h123, 12'h000, 12'h000);
    repeat (4) tick();
    check("postrst_count", 32'(got.size()), 32'd1);
    check("postrst_word", word_at(0), 32'h12AB_FE45);

    // Mode switch 1 -> 0 discards the pending half.
    got.delete();
    apply_set(1'b1, 2'b01, 12'h7F0, 12'h0F0, 12'h000, 12'h000);
    repeat (2) tick();
    apply_set(1'b0, 2'b01, 12'h801, 12'h7FE, 12'h000, 12'h000);
    repeat (4) tick();
    check("mswitch_count", 32'(got.size()), 32'd1);
    check("mswitch_word", word_at(0), 32'h07FE_F801);
    check("mswitch_ovr", 32'(ovr_cnt), 32'd0);
    check("mswitch_ovf", 32'(ovf_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
